// File: rtl/ram_arbiter_if.sv
// Shared bus between the two RAM requesters (ports C and D), the arbiter and
// the single-port genram. The arbiter is the slave of both requesters and
// drives the RAM side; the requesters use the master view, the RAM the mem view.
interface ram_arbiter_if #(
  parameter int AW = 9,
  parameter int DW = 12
) ();

  // Port C: Simplez CPU
  logic          c_req;
  logic          c_rw;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_din;
  logic          c_ack;
  logic [DW-1:0] c_dout;

  // Port D: serial loader / debug monitor
  logic          d_req;
  logic          d_rw;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_din;
  logic          d_ack;
  logic [DW-1:0] d_dout;

  // RAM side
  logic          ram_cs;
  logic          ram_rw;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;

  // Arbiter status
  logic          busy;

  // Arbiter view
  modport slave (
    input  c_req, c_rw, c_addr, c_din,
    input  d_req, d_rw, d_addr, d_din,
    input  ram_dout,
    output c_ack, c_dout,
    output d_ack, d_dout,
    output ram_cs, ram_rw, ram_addr, ram_din,
    output busy
  );

  // Requester view (both ports)
  modport master (
    output c_req, c_rw, c_addr, c_din,
    output d_req, d_rw, d_addr, d_din,
    input  c_ack, c_dout,
    input  d_ack, d_dout,
    input  busy
  );

  // RAM view
  modport mem (
    input  ram_cs, ram_rw, ram_addr, ram_din,
    output ram_dout
  );

endinterface : ram_arbiter_if

// File: rtl/ram_arbiter.sv
// Two-requester arbiter for the 12-bit genram. Every access runs as a fixed
// IDLE -> ACCESS -> RESP sequence: the winner's request is latched in IDLE,
// presented to the RAM in ACCESS and acknowledged in RESP. Addresses at or
// above RAM_TOP belong to the peripheral window and never reach the RAM.
module ram_arbiter #(
  parameter int            AW      = 9,
  parameter int            DW      = 12,
  parameter logic [AW-1:0] RAM_TOP = 'h1F8,
  parameter bit            FIXED_C = 1'b0
) (
  input  logic          clk,
  input  logic          rstn,
  ram_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  localparam logic PORT_C = 1'b0;
  localparam logic PORT_D = 1'b1;

  // FSM state and latched transaction
  state_t        r_state;
  logic          r_last;      // port served by the previous access
  logic          r_gnt;       // port owning the current access
  logic          r_rw;        // latched direction of the current access
  logic          r_in_range;  // latched address < RAM_TOP

  // Registered outputs
  logic          r_c_ack;
  logic          r_d_ack;
  logic [DW-1:0] r_c_dout;
  logic [DW-1:0] r_d_dout;
  logic          r_ram_cs;
  logic          r_ram_rw;
  logic [AW-1:0] r_ram_addr;
  logic [DW-1:0] r_ram_din;

  // Arbitration result and the winner's request fields
  logic          w_any_req;
  logic          w_pick;
  logic          w_sel_rw;
  logic [AW-1:0] w_sel_addr;
  logic [DW-1:0] w_sel_din;

  // Read return path
  logic          w_resp_rd;
  logic [DW-1:0] w_rd_data;

  assign w_any_req = bus.c_req | bus.d_req;

  // Pick the winner among pending requests and mux its fields.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    w_pick     = PORT_C;
    w_sel_rw   = bus.c_rw;
    w_sel_addr = bus.c_addr;
    w_sel_din  = bus.c_din;
    // D wins when alone, or on a tie in round-robin mode when C went last.
    if (bus.d_req && (!bus.c_req || (!FIXED_C && r_last == PORT_C))) begin
      w_pick     = PORT_D;
      w_sel_rw   = bus.d_rw;
      w_sel_addr = bus.d_addr;
      w_sel_din  = bus.d_din;
    end
  end

  // The RAM output register only holds valid data during RESP of an
  // in-range read; out-of-range reads return zero.
  assign w_resp_rd = (r_state == S_RESP) && r_rw && rstn;
  assign w_rd_data = r_in_range ? bus.ram_dout : '0;

  // Transaction sequencer: latch in IDLE, drive RAM in ACCESS, ack in RESP.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!rstn) begin
      r_state    <= S_IDLE;
      r_last     <= PORT_D;  // C wins the first tie after reset
      r_gnt      <= PORT_C;
      r_rw       <= 1'b1;
      r_in_range <= 1'b0;
      r_c_ack    <= 1'b0;
      r_d_ack    <= 1'b0;
      r_c_dout   <= '0;
      r_d_dout   <= '0;
      r_ram_cs   <= 1'b0;
      r_ram_rw   <= 1'b1;
      r_ram_addr <= '0;
      r_ram_din  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_gnt      <= w_pick;
            r_rw       <= w_sel_rw;
            r_in_range <= (w_sel_addr < RAM_TOP);
            // RAM pins load here so they are valid for the whole ACCESS cycle.
            r_ram_cs   <= (w_sel_addr < RAM_TOP);
            r_ram_rw   <= w_sel_rw;
            r_ram_addr <= w_sel_addr;
            r_ram_din  <= w_sel_din;
            r_state    <= S_ACCESS;
          end
        end

        S_ACCESS: begin
          // Release the RAM; address and data keep their last value.
          r_ram_cs <= 1'b0;
          r_ram_rw <= 1'b1;
          r_c_ack  <= (r_gnt == PORT_C);
          r_d_ack  <= (r_gnt == PORT_D);
          r_state  <= S_RESP;
        end

        S_RESP: begin
          r_c_ack <= 1'b0;
          r_d_ack <= 1'b0;
          // Capture read data so dout holds until the port's next ack.
          if (r_rw) begin
            if (r_gnt == PORT_C) r_c_dout <= w_rd_data;
            else                 r_d_dout <= w_rd_data;
          end
          r_last  <= r_gnt;
          r_state <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Acks and RAM strobes are masked while rstn is low so a reset that lands
  // mid-transaction cannot complete a pending write or leak an ack.
  assign bus.c_ack    = r_c_ack & rstn;
  assign bus.d_ack    = r_d_ack & rstn;
  assign bus.ram_cs   = r_ram_cs & rstn;
  assign bus.ram_rw   = r_ram_rw | ~rstn;
  assign bus.ram_addr = r_ram_addr;
  assign bus.ram_din  = r_ram_din;
  assign bus.busy     = (r_state != S_IDLE);

  // Read data is valid in the same cycle as the ack, straight from the RAM
  // register, and is held afterwards from the captured copy.
  assign bus.c_dout = (w_resp_rd && r_gnt == PORT_C) ? w_rd_data : r_c_dout;
  assign bus.d_dout = (w_resp_rd && r_gnt == PORT_D) ? w_rd_data : r_d_dout;

endmodule : ram_arbiter

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: instance A runs round-robin, instance B
// fixed-priority C. Each instance gets a behavioural genram (registered read,
// one cycle after ram_cs).
module tb_ram_arbiter;

  logic clk = 1'b0;
  logic rstn;

  always #5 clk = ~clk;

  ram_arbiter_if if_a ();
  ram_arbiter_if if_b ();

  ram_arbiter #(.FIXED_C(1'b0)) u_dut_a (.clk(clk), .rstn(rstn), .bus(if_a));
  ram_arbiter #(.FIXED_C(1'b1)) u_dut_b (.clk(clk), .rstn(rstn), .bus(if_b));

  // Behavioural RAMs
  logic [11:0] mem_a [512] = '{default: '0};
  logic [11:0] mem_b [512] = '{default: '0};

  always @(posedge clk) begin
    if (if_a.ram_cs) begin
      if (if_a.ram_rw) if_a.ram_dout <= mem_a[if_a.ram_addr];
      else             mem_a[if_a.ram_addr] <= if_a.ram_din;
    end
  end

  always @(posedge clk) begin
    if (if_b.ram_cs) begin
      if (if_b.ram_rw) if_b.ram_dout <= mem_b[if_b.ram_addr];
      else             mem_b[if_b.ram_addr] <= if_b.ram_din;
    end
  end

  // Bookkeeping
  int n_tot  = 0;
  int n_bad  = 0;
  int cs_a   = 0;
  int both_a = 0;
  int both_b = 0;

  always @(negedge clk) begin
    if (if_a.ram_cs) cs_a++;
    if (if_a.c_ack && if_a.d_ack) both_a++;
    if (if_b.c_ack && if_b.d_ack) both_b++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait for the next ack on instance A (sel_b=0) or B (sel_b=1).
  // who: 0=C, 1=D, 2=both, 3=timeout; lat counts clock edges waited.
  task automatic wait_ack(input bit sel_b, output int who, output int lat);
    logic c, d;
    who = 3;
    lat = 0;
    while (who == 3 && lat < 8) begin
      tick();
      lat++;
      c = sel_b ? if_b.c_ack : if_a.c_ack;
      d = sel_b ? if_b.d_ack : if_a.d_ack;
      if (c && d)  who = 2;
      else if (c)  who = 0;
      else if (d)  who = 1;
    end
  endtask

  // One complete access on instance A from port p (0=C, 1=D), started in
  // IDLE. Checks ack latency, RAM strobe count and the port's dout in the
  // ack cycle, then drops req and steps back into IDLE.
  task automatic access_a(input bit p, input bit rw, input logic [8:0] addr,
                          input logic [11:0] din, input logic [11:0] exp_dout,
                          input int exp_cs, input string tag);
    int cs0, who, lat;
    cs0 = cs_a;
    if (!p) begin
      if_a.c_rw = rw; if_a.c_addr = addr; if_a.c_din = din; if_a.c_req = 1'b1;
    end else begin
      if_a.d_rw = rw; if_a.d_addr = addr; if_a.d_din = din; if_a.d_req = 1'b1;
    end
    wait_ack(1'b0, who, lat);
    check({tag, "_who"}, who, p);
    check({tag, "_lat"}, lat, 2);
    check({tag, "_cs"}, cs_a - cs0, exp_cs);
    check({tag, "_dout"}, p ? if_a.d_dout : if_a.c_dout, exp_dout);
    if (!p) if_a.c_req = 1'b0;
    else    if_a.d_req = 1'b0;
    tick();
  endtask

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int who, lat, seen;

    if_a.c_req = 0; if_a.c_rw = 1; if_a.c_addr = '0; if_a.c_din = '0;
    if_a.d_req = 0; if_a.d_rw = 1; if_a.d_addr = '0; if_a.d_din = '0;
    if_b.c_req = 0; if_b.c_rw = 1; if_b.c_addr = '0; if_b.c_din = '0;
    if_b.d_req = 0; if_b.d_rw = 1; if_b.d_addr = '0; if_b.d_din = '0;
    rstn = 1'b0;
    tick();
    tick();
    rstn = 1'b1;

    // Reset state
    check("rst_c_ack",    if_a.c_ack,    0);
    check("rst_d_ack",    if_a.d_ack,    0);
    check("rst_c_dout",   if_a.c_dout,   0);
    check("rst_d_dout",   if_a.d_dout,   0);
    check("rst_ram_cs",   if_a.ram_cs,   0);
    check("rst_ram_rw",   if_a.ram_rw,   1);
    check("rst_ram_addr", if_a.ram_addr, 0);
    check("rst_ram_din",  if_a.ram_din,  0);
    check("rst_busy",     if_a.busy,     0);

    // 1: C write then read back; last in-range address too
    access_a(0, 0, 9'h010, 12'h123, 12'h000, 1, "t1_wr");
    check("t1_mem",       mem_a[9'h010], 12'h123);
    check("t1_addr_hold", if_a.ram_addr, 9'h010);
    check("t1_rw_idle",   if_a.ram_rw,   1);
    access_a(0, 1, 9'h010, 12'h000, 12'h123, 1, "t1_rd");
    access_a(0, 0, 9'h1F7, 12'hABC, 12'h123, 1, "t1_wr_top");
    access_a(0, 1, 9'h1F7, 12'h000, 12'hABC, 1, "t1_rd_top");

    // 4: D out-of-range accesses never strobe the RAM
    access_a(1, 1, 9'h010, 12'h000, 12'h123, 1, "t4_rd_in");
    access_a(1, 0, 9'h1FD, 12'h777, 12'h123, 0, "t4_wr_oor");
    check("t4_mem_1fd", mem_a[9'h1FD], 12'h000);
    access_a(1, 1, 9'h1F8, 12'h000, 12'h000, 0, "t4_rd_1f8");
    access_a(1, 1, 9'h1F7, 12'h000, 12'hABC, 1, "t4_rd_1f7");
    access_a(1, 1, 9'h1FF, 12'h000, 12'h000, 0, "t4_rd_1ff");

    // 6: C request arriving during D's ACCESS waits for the next IDLE
    access_a(0, 0, 9'h000, 12'h321, 12'hABC, 1, "t6_wr0");
    if_a.d_rw = 1; if_a.d_addr = 9'h000; if_a.d_req = 1;
    tick();
    check("t6_access_cs", if_a.ram_cs, 1);
    if_a.c_rw = 1; if_a.c_addr = 9'h1F7; if_a.c_req = 1;
    tick();
    check("t6_d_ack", if_a.d_ack,  1);
    check("t6_c_ack", if_a.c_ack,  0);
    check("t6_d_dout", if_a.d_dout, 12'h321);
    if_a.d_req = 0;
    wait_ack(1'b0, who, lat);
    check("t6_c_who", who, 0);
    check("t6_c_gap", lat, 3);
    check("t6_c_dout", if_a.c_dout, 12'hABC);
    if_a.c_req = 0;
    tick();

    // 5: reset during ACCESS of a C write aborts it
    if_a.c_rw = 0; if_a.c_addr = 9'h010; if_a.c_din = 12'h456; if_a.c_req = 1;
    tick();
    check("t5_access_cs", if_a.ram_cs, 1);
    rstn = 1'b0;
    if_a.c_req = 0;
    tick();
    check("t5_c_ack",    if_a.c_ack,    0);
    check("t5_busy",     if_a.busy,     0);
    check("t5_c_dout",   if_a.c_dout,   0);
    check("t5_d_dout",   if_a.d_dout,   0);
    check("t5_ram_cs",   if_a.ram_cs,   0);
    check("t5_ram_rw",   if_a.ram_rw,   1);
    check("t5_ram_addr", if_a.ram_addr, 0);
    check("t5_ram_din",  if_a.ram_din,  0);
    rstn = 1'b1;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (if_a.c_ack || if_a.d_ack) seen++;
    end
    check("t5_no_ack", seen, 0);
    check("t5_mem", mem_a[9'h010], 12'h123);
    access_a(0, 1, 9'h010, 12'h000, 12'h123, 1, "t5_reread");

    // 2: both ports request continuously, round-robin from reset -> C,D,C,D
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    if_a.c_rw = 1; if_a.c_addr = 9'h010; if_a.c_req = 1;
    if_a.d_rw = 1; if_a.d_addr = 9'h000; if_a.d_req = 1;
    for (int i = 0; i < 4; i++) begin
      wait_ack(1'b0, who, lat);
      check($sformatf("t2_who%0d", i), who, i % 2);
      check($sformatf("t2_lat%0d", i), lat, (i == 0) ? 2 : 3);
    end
    if_a.c_req = 0;
    if_a.d_req = 0;
    check("t2_c_dout", if_a.c_dout, 12'h123);
    check("t2_d_dout", if_a.d_dout, 12'h321);
    tick();

    // 3: fixed priority. A C-only write first so that a round-robin
    // arbiter would favour D on the following tie.
    if_b.c_rw = 0; if_b.c_addr = 9'h020; if_b.c_din = 12'h0F0; if_b.c_req = 1;
    wait_ack(1'b1, who, lat);
    check("t3_wr_who", who, 0);
    check("t3_wr_lat", lat, 2);
    if_b.c_rw = 1; if_b.c_addr = 9'h020;
    if_b.d_rw = 1; if_b.d_addr = 9'h020; if_b.d_req = 1;
    for (int i = 0; i < 3; i++) begin
      wait_ack(1'b1, who, lat);
      check($sformatf("t3_c_who%0d", i), who, 0);
      check($sformatf("t3_c_lat%0d", i), lat, 3);
    end
    if_b.c_req = 0;
    wait_ack(1'b1, who, lat);
    check("t3_d_who", who, 1);
    check("t3_d_lat", lat, 3);
    check("t3_d_dout", if_b.d_dout, 12'h0F0);
    check("t3_c_dout", if_b.c_dout, 12'h0F0);
    if_b.d_req = 0;
    tick();
    tick();

    check("both_acks_a", both_a, 0);
    check("both_acks_b", both_b, 0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule : tb_ram_arbiter
